mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MEM_LAT, default 4, main-memory read/write latency in cycles (legal 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
REQ-004 ic_req  input  1  I-cache miss fill request; level, held until ic_done.
REQ-005 ic_addr  input  16  I-cache fill address.
REQ-006 ic_done  output  1  one-cycle pulse; ic_rdata valid.
REQ-007 ic_rdata  output  16  fill data to I-cache.
REQ-008 dc_req  input  1  D-cache miss/writeback request; level, held until dc_done.
REQ-009 dc_wr  input  1  1 = write, 0 = read; qualified by dc_req.
REQ-010 dc_addr  input  16  D-cache request address.
REQ-011 dc_wdata  input  16  D-cache write data.
REQ-012 dc_done  output  1  one-cycle pulse; dc_rdata valid on reads.
REQ-013 dc_rdata  output  16  read data to D-cache.
REQ-014 mem_en  output  1  memory access strobe, one cycle per transaction.
REQ-015 mem_wr  output  1  memory write enable, valid with mem_en.
REQ-016 mem_addr  output  16  memory address, held from issue through done.
REQ-017 mem_wdata  output  16  memory write data, held from issue through done.
REQ-018 mem_rdata  input  16  memory read data, valid MEM_LAT cycles after mem_en.
REQ-019 busy  output  1  high in any state other than IDLE.

Function
REQ-020 FSM states IDLE, ISSUE, WAIT, DONE; encoding free.
REQ-021 IDLE: no request -> stay; any request -> grant per REQ-027, latch owner, addr, wr, wdata; -> ISSUE.
REQ-022 ISSUE: mem_en=1, mem_wr=latched wr (0 for I-cache); load wait counter with MEM_LAT-1; -> WAIT (-> DONE directly if MEM_LAT=1).
REQ-023 WAIT: decrement counter each cycle; counter 0 -> capture mem_rdata into data register, -> DONE.
REQ-024 DONE: pulse owner's done for exactly one cycle; rdata held stable until the next capture; -> IDLE.
REQ-025 Latency: request seen at edge t -> mem_en in cycle t+1 -> done in cycle t+1+MEM_LAT.
REQ-026 Requests raised in ISSUE/WAIT/DONE are not lost: they remain pending and are arbitrated in the next IDLE; inputs other than req are ignored outside IDLE.
REQ-027 Default arbitration: fixed priority, D-cache over I-cache.
REQ-028 Simultaneous ic_req and dc_req in IDLE: exactly one grant; the other is serviced in a following transaction.
REQ-029 Requester deasserts req in the cycle after done; a req still high in the DONE cycle is ignored until IDLE.
REQ-030 Never more than one outstanding memory transaction; mem_en never asserted outside ISSUE.
REQ-031 dc_wr write: dc_done pulses on the same schedule; dc_rdata unchanged.

Reset
REQ-032 rst=0 at rising edge: state=IDLE, counter=0, owner=D-cache, rr pointer=I-cache next.
REQ-033 Outputs after reset: ic_done=0, dc_done=0, mem_en=0, mem_wr=0, busy=0, mem_addr/mem_wdata/ic_rdata/dc_rdata=0x0000.
REQ-034 Reset mid-transaction: abort immediately, no done pulse, no later mem_en for the aborted request.

Configuration
REQ-035 Macro MEM_ARB_RR_EN defined: round-robin arbitration; on a tie, grant the requester not served last; pointer updates on each grant.
REQ-036 MEM_ARB_RR_EN undefined: fixed priority per REQ-027; no pointer logic.

Verification
REQ-037 Reset -> busy=0, mem_en=0, both done=0, data outputs 0x0000.
REQ-038 MEM_LAT=4; ic_req, ic_addr=0x0040, mem_rdata=0xBEEF -> mem_en one cycle after request, ic_done 4 cycles later, ic_rdata=0xBEEF.
REQ-039 dc_req, dc_wr=1, dc_addr=0x1234, dc_wdata=0xA5A5 -> mem_en=1, mem_wr=1, mem_addr=0x1234, mem_wdata=0xA5A5, dc_done after MEM_LAT.
REQ-040 ic_req and dc_req together, both held -> fixed priority: D then I. RR build with repeated ties: grants alternate I, D, I, D.
REQ-041 rst=0 during WAIT -> no done pulse; next request serviced normally from IDLE.
REQ-042 dc_req raised during an I-cache WAIT -> serviced immediately after I-cache DONE, exactly one mem_en per transaction.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one main-memory port between an I-cache fill path
// and a D-cache miss/writeback path.
//
// One transaction at a time moves through IDLE -> ISSUE -> WAIT -> DONE.
// A request seen at rising edge t gives mem_en in cycle t+1 and the owner's
// done pulse in cycle t+1+MEM_LAT.
//
// Parameters
//   MEM_LAT    main-memory latency in cycles (legal range 1..15)
//
// Configuration macro
//   MEM_ARB_RR_EN  defined: round-robin arbitration between the two caches.
//                  undefined (default): fixed priority, D-cache over I-cache.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-low reset
//   ic_req     I-cache fill request (level, held until ic_done)
//   ic_addr    I-cache fill address
//   ic_done    one-cycle pulse, ic_rdata valid
//   ic_rdata   fill data returned to the I-cache
//   dc_req     D-cache request (level, held until dc_done)
//   dc_wr      1 = write, 0 = read, qualified by dc_req
//   dc_addr    D-cache request address
//   dc_wdata   D-cache write data
//   dc_done    one-cycle pulse, dc_rdata valid on reads
//   dc_rdata   read data returned to the D-cache
//   mem_en     memory access strobe, one cycle per transaction
//   mem_wr     memory write enable, valid with mem_en
//   mem_addr   memory address, held from issue through done
//   mem_wdata  memory write data, held from issue through done
//   mem_rdata  memory read data
//   busy       high whenever a transaction is in flight
module mem_arbiter #(
  parameter int unsigned MEM_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ic_req,
  input  logic [15:0] ic_addr,
  output logic        ic_done,
  output logic [15:0] ic_rdata,
  input  logic        dc_req,
  input  logic        dc_wr,
  input  logic [15:0] dc_addr,
  input  logic [15:0] dc_wdata,
  output logic        dc_done,
  output logic [15:0] dc_rdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        owner_dc_q, owner_dc_d;   // 1 = D-cache owns the transaction
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] ic_rdata_q, ic_rdata_d;
  logic [15:0] dc_rdata_q, dc_rdata_d;
  logic        grant_dc;
  logic        capture;

`ifdef MEM_ARB_RR_EN
  // ptr_q = 1: the I-cache wins the next tie (the D-cache was served last).
  logic        ptr_q, ptr_d;
`endif

  // Arbitration: only evaluated in IDLE, when at least one request is up.
`ifdef MEM_ARB_RR_EN
  assign grant_dc = dc_req & (~ic_req | ~ptr_q);
`else
  assign grant_dc = dc_req;
`endif

  // The counter is loaded with MEM_LAT-1 in ISSUE and decremented in WAIT;
  // data is captured on the edge where the decremented value becomes zero,
  // so DONE lands exactly MEM_LAT cycles after the ISSUE cycle.
  assign capture = ((state_q == S_ISSUE) && (MEM_LAT == 1)) ||
                   ((state_q == S_WAIT)  && (cnt_q == 4'd1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_dc_d = owner_dc_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ic_rdata_d = ic_rdata_q;
    dc_rdata_d = dc_rdata_q;
`ifdef MEM_ARB_RR_EN
    ptr_d      = ptr_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (ic_req || dc_req) begin
          owner_dc_d = grant_dc;
          addr_d     = grant_dc ? dc_addr : ic_addr;
          wr_d       = grant_dc & dc_wr;
          wdata_d    = grant_dc ? dc_wdata : '0;
`ifdef MEM_ARB_RR_EN
          ptr_d      = grant_dc;
`endif
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = LAT_M1;
        state_d = (MEM_LAT == 1) ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Writes leave the owner's read-data register untouched.
    if (capture && !wr_q) begin
      if (owner_dc_q) begin
        dc_rdata_d = mem_rdata;
      end else begin
        ic_rdata_d = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      owner_dc_q <= 1'b1;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ic_rdata_q <= '0;
      dc_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_dc_q <= owner_dc_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ic_rdata_q <= ic_rdata_d;
      dc_rdata_q <= dc_rdata_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= 1'b1;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign mem_en    = (state_q == S_ISSUE);
  assign mem_wr    = (state_q == S_ISSUE) & wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign ic_done   = (state_q == S_DONE) & ~owner_dc_q;
  assign dc_done   = (state_q == S_DONE) &  owner_dc_q;
  assign ic_rdata  = ic_rdata_q;
  assign dc_rdata  = dc_rdata_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int MEM_LAT = 4;

  logic        clk;
  logic        rst;
  logic        ic_req;
  logic [15:0] ic_addr;
  logic        ic_done;
  logic [15:0] ic_rdata;
  logic        dc_req;
  logic        dc_wr;
  logic [15:0] dc_addr;
  logic [15:0] dc_wdata;
  logic        dc_done;
  logic [15:0] dc_rdata;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;

  int errors = 0;
  int checks = 0;
  bit chk_on = 0;

  mem_arbiter #(.MEM_LAT(MEM_LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .ic_req   (ic_req),
    .ic_addr  (ic_addr),
    .ic_done  (ic_done),
    .ic_rdata (ic_rdata),
    .dc_req   (dc_req),
    .dc_wr    (dc_wr),
    .dc_addr  (dc_addr),
    .dc_wdata (dc_wdata),
    .dc_done  (dc_done),
    .dc_rdata (dc_rdata),
    .mem_en   (mem_en),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents as a pure function of address; 0x0040 holds 0xBEEF.
  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return (a == 16'h0040) ? 16'hBEEF : (a ^ 16'h3C5A);
  endfunction

  assign mem_rdata = mem_fn(mem_addr);

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // rem = cycles left in the current transaction (MEM_LAT+1 total):
  // first cycle carries mem_en, last cycle carries done.
  int          rem = 0;
  bit          m_own_dc = 1;
  bit          m_wr = 0;
  logic [15:0] m_addr = '0;
  logic [15:0] m_wdata = '0;
  logic [15:0] m_ic_rd = '0;
  logic [15:0] m_dc_rd = '0;
  bit          m_last_dc = 1;

  always @(posedge clk) begin
    bit g;
    if (!rst) begin
      rem = 0; m_own_dc = 1; m_wr = 0; m_addr = '0; m_wdata = '0;
      m_ic_rd = '0; m_dc_rd = '0; m_last_dc = 1;
    end else if (rem > 0) begin
      rem = rem - 1;
      if (rem == 1 && !m_wr) begin
        if (m_own_dc) m_dc_rd = mem_fn(m_addr);
        else          m_ic_rd = mem_fn(m_addr);
      end
    end else if (ic_req || dc_req) begin
`ifdef MEM_ARB_RR_EN
      g = dc_req && (!ic_req || !m_last_dc);
`else
      g = dc_req;
`endif
      m_own_dc  = g;
      m_last_dc = g;
      m_wr      = g && dc_wr;
      m_addr    = g ? dc_addr : ic_addr;
      m_wdata   = g ? dc_wdata : 16'h0000;
      rem       = MEM_LAT + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy",    {15'b0, busy},    {15'b0, rem > 0});
      chk("mem_en",  {15'b0, mem_en},  {15'b0, rem == MEM_LAT + 1});
      chk("ic_done", {15'b0, ic_done}, {15'b0, rem == 1 && !m_own_dc});
      chk("dc_done", {15'b0, dc_done}, {15'b0, rem == 1 && m_own_dc});
      chk("ic_rdata", ic_rdata, m_ic_rd);
      chk("dc_rdata", dc_rdata, m_dc_rd);
      if (rem == MEM_LAT + 1) chk("mem_wr", {15'b0, mem_wr}, {15'b0, m_wr});
      if (rem > 0) chk("mem_addr", mem_addr, m_addr);
      if (rem > 0 && m_wr) chk("mem_wdata", mem_wdata, m_wdata);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle n=1 is the cycle in which the request is first visible (the grant
  // edge ends it). Requests are dropped in the cycle after their done.
  task automatic run(input int max_n, input bit want_ic, input bit want_dc,
                     input int raise_dc_at,
                     output int en_n, output int en_cnt, output int ic_n, output int dc_n,
                     output logic [15:0] en_addr, output logic [15:0] en_wdata,
                     output logic en_wr);
    en_n = -1; en_cnt = 0; ic_n = -1; dc_n = -1;
    en_addr = '0; en_wdata = '0; en_wr = 1'b0;
    for (int n = 1; n <= max_n; n++) begin
      @(negedge clk);
      if (mem_en) begin
        en_cnt++;
        if (en_n < 0) begin
          en_n = n; en_addr = mem_addr; en_wdata = mem_wdata; en_wr = mem_wr;
        end
      end
      if (ic_done && ic_n < 0) ic_n = n;
      if (dc_done && dc_n < 0) dc_n = n;
      @(posedge clk);
      #1;
      if (ic_n >= 0) ic_req = 1'b0;
      if (dc_n >= 0) dc_req = 1'b0;
      if (n == raise_dc_at) dc_req = 1'b1;
      if ((!want_ic || ic_n >= 0) && (!want_dc || dc_n >= 0)) break;
    end
  endtask

  int en_n, en_cnt, ic_n, dc_n;
  logic [15:0] en_addr, en_wdata;
  logic en_wr;

  initial begin
    rst = 1'b0; ic_req = 1'b0; ic_addr = '0;
    dc_req = 1'b0; dc_wr = 1'b0; dc_addr = '0; dc_wdata = '0;
    tick(); tick();
    @(negedge clk);
    chk("rst_busy",    {15'b0, busy},    16'h0000);
    chk("rst_mem_en",  {15'b0, mem_en},  16'h0000);
    chk("rst_mem_wr",  {15'b0, mem_wr},  16'h0000);
    chk("rst_ic_done", {15'b0, ic_done}, 16'h0000);
    chk("rst_dc_done", {15'b0, dc_done}, 16'h0000);
    chk("rst_mem_addr",  mem_addr,  16'h0000);
    chk("rst_mem_wdata", mem_wdata, 16'h0000);
    chk("rst_ic_rdata",  ic_rdata,  16'h0000);
    chk("rst_dc_rdata",  dc_rdata,  16'h0000);
    @(posedge clk); #1;
    rst = 1'b1;
    chk_on = 1;
    tick();

    // I-cache fill of 0x0040
    ic_req = 1'b1; ic_addr = 16'h0040;
    run(40, 1, 0, 0, en_n, en_cnt, ic_n, dc_n, en_addr, en_wdata, en_wr);
    chk("ic_en_cycle",   16'(en_n), 16'd2);
    chk("ic_done_cycle", 16'(ic_n), 16'd6);
    chk("ic_en_addr",    en_addr,   16'h0040);
    chk("ic_rdata_val",  ic_rdata,  16'hBEEF);
    tick();

    // D-cache write
    dc_req = 1'b1; dc_wr = 1'b1; dc_addr = 16'h1234; dc_wdata = 16'hA5A5;
    run(40, 0, 1, 0, en_n, en_cnt, ic_n, dc_n, en_addr, en_wdata, en_wr);
    chk("dw_en_cycle",   16'(en_n), 16'd2);
    chk("dw_mem_wr",     {15'b0, en_wr}, 16'h0001);
    chk("dw_mem_addr",   en_addr,   16'h1234);
    chk("dw_mem_wdata",  en_wdata,  16'hA5A5);
    chk("dw_done_cycle", 16'(dc_n), 16'd6);
    chk("dw_rdata_kept", dc_rdata,  16'h0000);
    tick();

    // D-cache read of 0x0100
    dc_req = 1'b1; dc_wr = 1'b0; dc_addr = 16'h0100; dc_wdata = 16'hFFFF;
    run(40, 0, 1, 0, en_n, en_cnt, ic_n, dc_n, en_addr, en_wdata, en_wr);
    chk("dr_mem_wr",     {15'b0, en_wr}, 16'h0000);
    chk("dr_done_cycle", 16'(dc_n), 16'd6);
    chk("dr_rdata",      dc_rdata,  16'h3D5A);

    // Two ties in a row, both requests held until their own done
    for (int k = 0; k < 2; k++) begin
      tick();
      ic_req = 1'b1; ic_addr = 16'h0400 + 16'(k);
      dc_req = 1'b1; dc_wr = 1'b0; dc_addr = 16'h0800 + 16'(k);
      run(60, 1, 1, 0, en_n, en_cnt, ic_n, dc_n, en_addr, en_wdata, en_wr);
      chk("tie_en_count", 16'(en_cnt), 16'd2);
`ifdef MEM_ARB_RR_EN
      chk("tie_ic_first", 16'(ic_n), 16'd6);
      chk("tie_dc_second", 16'(dc_n), 16'd12);
`else
      chk("tie_dc_first", 16'(dc_n), 16'd6);
      chk("tie_ic_second", 16'(ic_n), 16'd12);
`endif
    end
    tick();

    // Reset during WAIT aborts the fill silently
    ic_req = 1'b1; ic_addr = 16'h0200;
    for (int n = 1; n <= 3; n++) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0; ic_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    run(10, 1, 1, 0, en_n, en_cnt, ic_n, dc_n, en_addr, en_wdata, en_wr);
    chk("abort_en_count", 16'(en_cnt), 16'd0);
    chk("abort_ic_done",  16'(ic_n),   16'hFFFF);
    chk("abort_dc_done",  16'(dc_n),   16'hFFFF);
    chk("abort_ic_rdata", ic_rdata,    16'h0000);

    dc_req = 1'b1; dc_wr = 1'b0; dc_addr = 16'h0300;
    run(40, 0, 1, 0, en_n, en_cnt, ic_n, dc_n, en_addr, en_wdata, en_wr);
    chk("post_rst_done", 16'(dc_n), 16'd6);
    chk("post_rst_data", dc_rdata,  16'h3F5A);
    tick();

    // D-cache write raised while an I-cache fill is waiting
    ic_req = 1'b1; ic_addr = 16'h0500;
    dc_wr = 1'b1; dc_addr = 16'h0600; dc_wdata = 16'h1357;
    run(60, 1, 1, 2, en_n, en_cnt, ic_n, dc_n, en_addr, en_wdata, en_wr);
    chk("late_en_count", 16'(en_cnt), 16'd2);
    chk("late_ic_done",  16'(ic_n),   16'd6);
    chk("late_dc_done",  16'(dc_n),   16'd12);
    chk("late_ic_rdata", ic_rdata,    16'h395A);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
